mac_tx_gmii: RTL and testbench



---
 rtl/eth_switch_pkg.sv | 29 ++
 rtl/crc32_d8.sv | 19 +
 rtl/mac_tx_gmii.sv | 152 +++++++++++++++
 tb/tb_mac_tx_gmii.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_switch_pkg.sv
// Shared switch constants and the transmit MAC state encoding.
// Also used by the receive MAC and the CRC helper.
package eth_switch_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam int          PTR_LEN_MSB   = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PTR_LAT = 3'd1,
    ST_PRE     = 3'd2,
    ST_SFD     = 3'd3,
    ST_DATA    = 3'd4,
    ST_PAD     = 3'd5,
    ST_FCS     = 3'd6,
    ST_IFG     = 3'd7
  } tx_state_e;

  // Bit-reversal turns the normal-form polynomial into the LSB-first form.
  function automatic logic [31:0] refl32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the Ethernet CRC32 (reflected, LSB first).
// Shared by the transmit FCS generator and the receive checker.
module crc32_d8
  import eth_switch_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_R = refl32(CRC32_POLY);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? POLY_R : 32'h0);
  end

endmodule

// File: rtl/mac_tx_gmii.sv
// Per-port GMII transmit MAC: descriptor pop, preamble/SFD, data, zero pad,
// CRC32 FCS and inter-frame gap.
module mac_tx_gmii
  import eth_switch_pkg::*;
#(
  parameter int MIN_LEN      = 60,
  parameter int IFG_CYCLES   = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_enable,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy
);

  localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
  localparam logic [11:0] PRE_LAST = 12'(PREAMBLE_LEN - 1);
  localparam logic [11:0] IFG_LAST = 12'(IFG_CYCLES - 1);
  localparam logic [11:0] FCS_LAST = 12'd3;

  tx_state_e   state, state_nxt;
  logic [11:0] len, cnt;
  logic        cnt_clr;
  logic [31:0] crc, crc_nxt, fcs;
  logic [7:0]  crc_din;
  logic        crc_en;
  logic        ptr_rd_raw, data_rd_raw;
  logic        unused_desc;

  assign unused_desc = ^ptr_fifo_dout[15:12];
  assign fcs         = ~crc;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_din),
    .crc_next (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      len   <= '0;
      crc   <= CRC32_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_clr ? 12'd0 : cnt + 12'd1;
      if (state == ST_PTR_LAT) begin
        len <= ptr_fifo_dout[PTR_LEN_MSB:0];
        crc <= CRC32_INIT;
      end else if (crc_en) begin
        crc <= crc_nxt;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    ptr_rd_raw  = 1'b0;
    data_rd_raw = 1'b0;
    gmii_tx_en  = 1'b0;
    gmii_txd    = 8'h00;
    crc_din     = data_fifo_dout;
    crc_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (tx_enable && !ptr_fifo_empty) begin
          ptr_rd_raw = 1'b1;
          state_nxt  = ST_PTR_LAT;
        end
      end
      ST_PTR_LAT: begin
        cnt_clr   = 1'b1;
        state_nxt = (ptr_fifo_dout[PTR_LEN_MSB:0] == 12'd0) ? ST_IDLE : ST_PRE;
      end
      ST_PRE: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = PREAMBLE_BYTE;
        if (cnt == PRE_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_SFD;
        end
      end
      ST_SFD: begin
        gmii_tx_en  = 1'b1;
        gmii_txd    = SFD_BYTE;
        data_rd_raw = 1'b1;
        cnt_clr     = 1'b1;
        state_nxt   = ST_DATA;
      end
      ST_DATA: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = data_fifo_dout;
        crc_en     = 1'b1;
        if (cnt == len - 12'd1) begin
          // Padding continues counting from len up to MIN_LEN.
          if (len < MIN_L) begin
            state_nxt = ST_PAD;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = ST_FCS;
          end
        end else begin
          data_rd_raw = 1'b1;
        end
      end
      ST_PAD: begin
        gmii_tx_en = 1'b1;
        crc_din    = 8'h00;
        crc_en     = 1'b1;
        if (cnt == MIN_L - 12'd1) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_FCS;
        end
      end
      ST_FCS: begin
        gmii_tx_en = 1'b1;
        gmii_txd   = fcs[{cnt[1:0], 3'b000} +: 8];
        if (cnt == FCS_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IFG;
        end
      end
      ST_IFG: begin
        if (cnt == IFG_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ptr_fifo_rd  = rstn & ptr_rd_raw;
  assign data_fifo_rd = rstn & data_rd_raw;
  assign gmii_tx_er   = 1'b0;
  assign tx_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mac_tx_gmii.sv
// Scoreboard bench for mac_tx_gmii: FIFO models feed one of two instances
// (MIN_LEN=0 and default); expected bytes are popped as gmii_tx_en is seen.
module tb_mac_tx_gmii;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tx_enable = 1'b1;
  logic sel = 1'b0;
  logic mon_en = 1'b1;
  logic q_empty = 1'b1;
  logic [15:0] ptr_dout = '0;
  logic [7:0]  data_dout = '0;

  logic ptr_rd0, data_rd0, en0, er0, busy0;
  logic ptr_rd1, data_rd1, en1, er1, busy1;
  logic [7:0] txd0, txd1;
  logic ptr_rd, data_rd, en, er, busy;
  logic [7:0] txd;

  logic [15:0] pq[$];
  logic [7:0]  dq[$];
  logic [7:0]  exp_q[$];
  int ptr_cyc[$], rise_q[$], fall_q[$];
  int n_cmp = 0, n_err = 0;
  int n_en = 0, n_drd = 0, n_ptr = 0, cyc = 0;
  int epoch = 0, seen = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  mac_tx_gmii #(.MIN_LEN(0)) dut0 (
    .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
    .ptr_fifo_empty(sel ? 1'b1 : q_empty), .ptr_fifo_rd(ptr_rd0), .ptr_fifo_dout(ptr_dout),
    .data_fifo_rd(data_rd0), .data_fifo_dout(data_dout),
    .gmii_txd(txd0), .gmii_tx_en(en0), .gmii_tx_er(er0), .tx_busy(busy0)
  );

  mac_tx_gmii dut (
    .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
    .ptr_fifo_empty(sel ? q_empty : 1'b1), .ptr_fifo_rd(ptr_rd1), .ptr_fifo_dout(ptr_dout),
    .data_fifo_rd(data_rd1), .data_fifo_dout(data_dout),
    .gmii_txd(txd1), .gmii_tx_en(en1), .gmii_tx_er(er1), .tx_busy(busy1)
  );

  assign ptr_rd  = sel ? ptr_rd1  : ptr_rd0;
  assign data_rd = sel ? data_rd1 : data_rd0;
  assign en      = sel ? en1      : en0;
  assign er      = sel ? er1      : er0;
  assign busy    = sel ? busy1    : busy0;
  assign txd     = sel ? txd1     : txd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++)
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    return r;
  endfunction

  // Queues a frame for the default (MIN_LEN=60) instance.
  task automatic push_frame(input int len, input bit with_exp);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0]  b;
    pq.push_back(16'(len));
    if (with_exp) begin
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
    end
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      dq.push_back(b);
      c = crc_ref(c, b);
      if (with_exp) exp_q.push_back(b);
    end
    for (int i = len; i < 60; i++) begin
      c = crc_ref(c, 8'h00);
      if (with_exp) exp_q.push_back(8'h00);
    end
    c = ~c;
    if (with_exp) for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  // FIFO models: one-cycle read latency.
  always @(posedge clk) begin
    if (ptr_rd && pq.size() > 0) ptr_dout <= pq.pop_front();
    if (data_rd && dq.size() > 0) data_dout <= dq.pop_front();
  end

  always @(posedge clk) begin
    #2;
    q_empty = (pq.size() == 0);
  end

  always @(negedge clk) begin
    if (epoch != seen) begin
      seen = epoch;
      n_en = 0; n_drd = 0; n_ptr = 0;
      ptr_cyc.delete(); rise_q.delete(); fall_q.delete();
    end
    cyc++;
    if (ptr_rd) begin n_ptr++; ptr_cyc.push_back(cyc); end
    if (data_rd) n_drd++;
    if (en) n_en++;
    if (en && !prev_en) rise_q.push_back(cyc);
    if (!en && prev_en) fall_q.push_back(cyc);
    prev_en = en;
    if (mon_en && en) begin
      if (exp_q.size() == 0) chk("txd_extra", exp_q.size(), 1);
      else                   chk("txd", {24'h0, txd}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string tag);
    int k = 0;
    while (!en && k < 100) begin @(negedge clk); k++; end
    chk(tag, en, 1);
  endtask

  initial begin
    logic [7:0] crc_exp [4];
    crc_exp = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset with a frame pending on the MIN_LEN=0 instance.
    pq.push_back(16'h0009);
    for (int i = 0; i < 9; i++) dq.push_back(8'(8'h31 + i));
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(crc_exp[i]);
    repeat (3) @(negedge clk);
    chk("rst_ptr_rd", ptr_rd, 0);
    chk("rst_data_rd", data_rd, 0);
    chk("rst_tx_en", en, 0);
    chk("rst_txd", txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_er", er, 0);

    tick(); epoch++; rstn = 1'b1;
    repeat (60) @(negedge clk);
    chk("crc_tx_en_cycles", n_en, 21);
    chk("crc_data_rd", n_drd, 9);
    chk("crc_left", exp_q.size(), 0);
    chk("crc_rises", rise_q.size(), 1);
    if (rise_q.size() > 0 && ptr_cyc.size() > 0)
      chk("start_latency", rise_q[0] - ptr_cyc[0], 2);

    // Padding on the default instance.
    tick(); epoch++; sel = 1'b1;
    push_frame(10, 1);
    repeat (120) @(negedge clk);
    chk("pad_tx_en_cycles", n_en, 72);
    chk("pad_data_rd", n_drd, 10);
    chk("pad_left", exp_q.size(), 0);

    // Back-to-back 64-byte frames.
    tick(); epoch++;
    push_frame(64, 1);
    push_frame(64, 1);
    repeat (250) @(negedge clk);
    chk("b2b_left", exp_q.size(), 0);
    chk("b2b_rises", rise_q.size(), 2);
    chk("b2b_data_rd", n_drd, 128);
    if (rise_q.size() >= 2 && fall_q.size() >= 1 && ptr_cyc.size() >= 2) begin
      chk("b2b_gap", rise_q[1] - fall_q[0], 14);
      chk("b2b_ptr_rd", ptr_cyc[1] - (fall_q[0] - 1), 13);
    end

    // Zero-length descriptor.
    tick(); epoch++;
    pq.push_back(16'hF000);
    begin
      int k = 0;
      while (!ptr_rd && k < 20) begin @(negedge clk); k++; end
    end
    chk("zl_ptr_rd", ptr_rd, 1);
    @(negedge clk); chk("zl_busy_lat", busy, 1);
    @(negedge clk); chk("zl_idle", busy, 0);
    repeat (10) @(negedge clk);
    chk("zl_ptr_cnt", n_ptr, 1);
    chk("zl_data_rd", n_drd, 0);
    chk("zl_tx_en", n_en, 0);

    // Reset in the 5th DATA cycle, with another descriptor waiting.
    tick(); epoch++; mon_en = 1'b0;
    push_frame(20, 0);
    pq.push_back(16'h0010);
    wait_en("rst_frame_start");
    repeat (12) @(negedge clk);
    rstn = 1'b0;
    #1 chk("rst_mid_data_rd", data_rd, 0);
    @(negedge clk);
    chk("rst_mid_tx_en", en, 0);
    chk("rst_mid_ptr_rd", ptr_rd, 0);
    chk("rst_mid_txd", txd, 0);
    chk("rst_mid_busy", busy, 0);
    pq.delete(); dq.delete(); epoch++;
    repeat (3) @(negedge clk);
    chk("rst_mid_reads", n_drd + n_ptr, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rel_wait_ptr", n_ptr, 0);
    chk("rel_wait_idle", busy, 0);
    tick(); epoch++; mon_en = 1'b1;
    push_frame(64, 1);
    repeat (120) @(negedge clk);
    chk("rel_ptr_cnt", n_ptr, 1);
    chk("rel_left", exp_q.size(), 0);

    // tx_enable dropped mid-frame.
    tick(); epoch++;
    push_frame(16, 1);
    push_frame(16, 0);
    wait_en("txen_frame_start");
    tx_enable = 1'b0;
    repeat (150) @(negedge clk);
    chk("txen_ptr_cnt", n_ptr, 1);
    chk("txen_tx_en_cycles", n_en, 72);
    chk("txen_left", exp_q.size(), 0);
    chk("txen_stall_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
